t07_mmio_bridge: RTL and testbench

Bus-master bridge between `t07_memoryHandler` and the external memory/MMIO bus. It converts the handler's `rwi` request code (fetch, read, write) into single Wishbone-classic transactions and returns read data. It produces the `busy` level whose falling edge advances the handler's state machine. One transaction is issued per request, and a held request code is never re-issued.

---
 rtl/t07_mmio_bridge.sv | 128 ++++++++++++
 tb/tb_t07_mmio_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t07_mmio_bridge.sv
// Wishbone-classic bus master that turns memory-handler rwi requests into single transactions.
// Optional watchdog abort is built only when T07_MMIO_TIMEOUT_EN is defined.
module t07_mmio_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  rwi_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic [31:0] rdata_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        err_o
);

    // state | meaning
    // IDLE  | no request pending, waiting for a non-zero rwi code
    // REQ   | bus cycle outstanding, address/data held until ack
    // HOLD  | completed code may still be presented; only a different code relaunches
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    state_t     state;
    logic [1:0] op_q;
    logic       active;
    logic       start;

`ifdef T07_MMIO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign wb_cyc_o = active;
    assign wb_stb_o = active;
    assign busy_o   = active;
    assign wb_sel_o = 4'b1111;

    // A held completion code must not relaunch; only a new non-zero code does.
    always_comb begin
        start = 1'b0;
        if (rwi_i != OP_IDLE) begin
            if (state == IDLE) begin
                start = 1'b1;
            end else if ((state == HOLD) && (rwi_i != op_q)) begin
                start = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            op_q     <= OP_IDLE;
            active   <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            rdata_o  <= '0;
`ifdef T07_MMIO_TIMEOUT_EN
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (start) begin
                        wb_adr_o <= addr_i & 32'hFFFF_FFFC;
                        wb_dat_o <= wdata_i;
                        wb_we_o  <= (rwi_i == OP_WRITE);
                        op_q     <= rwi_i;
                        active   <= 1'b1;
                        state    <= REQ;
`ifdef T07_MMIO_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end else if (rwi_i == OP_IDLE) begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (wb_ack_i) begin
                        if (op_q != OP_WRITE) begin
                            rdata_o <= wb_dat_i;
                        end
                        active <= 1'b0;
                        state  <= HOLD;
`ifdef T07_MMIO_TIMEOUT_EN
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: release the bus and hand the handler a recognisable error word.
                        if (op_q != OP_WRITE) begin
                            rdata_o <= ERR_DATA;
                        end
                        err_q  <= 1'b1;
                        active <= 1'b0;
                        state  <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t07_mmio_bridge.sv
// Directed plus randomized bench for t07_mmio_bridge with a transaction-level reference model.
module tb_t07_mmio_bridge;

`ifdef T07_MMIO_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk;
    logic        nrst;
    logic [1:0]  rwi_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic [31:0] rdata_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int launches = 0;
    logic prev_cyc = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    t07_mmio_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(32'hBAD0_BAD0)) dut (
        .clk(clk), .nrst(nrst), .rwi_i(rwi_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .rdata_o(rdata_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus cycles are counted as rising edges of cyc, seen on the falling clock edge.
    always @(negedge clk) begin
        if (!prev_cyc && wb_cyc_o) launches <= launches + 1;
        prev_cyc <= wb_cyc_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; this edge is cycle 0. Returns at the falling edge of cycle lat+1.
    task automatic run_txn(input logic [1:0] code, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdval, input int lat);
        logic [31:0] exp_adr;
        exp_adr  = addr - (addr % 4);
        rwi_i    = code;
        addr_i   = addr;
        wdata_i  = wdata;
        wb_ack_i = 1'b0;
        @(negedge clk);
        chk("launch_busy", busy_o, 1);
        chk("launch_cyc", wb_cyc_o, 1);
        chk("launch_stb", wb_stb_o, 1);
        chk("launch_adr", wb_adr_o, exp_adr);
        chk("launch_we", wb_we_o, (code == 2'b01) ? 1 : 0);
        chk("launch_sel", wb_sel_o, 4'b1111);
        if (code == 2'b01) chk("launch_wdat", wb_dat_o, wdata);
        addr_i  = $urandom;
        wdata_i = $urandom;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(negedge clk);
                chk("req_busy", busy_o, 1);
                chk("req_adr_stable", wb_adr_o, exp_adr);
            end
            if (c == lat) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rdval;
            end
        end
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        if (code != 2'b01) exp_rdata = rdval;
        chk("done_busy", busy_o, 0);
        chk("done_cyc", wb_cyc_o, 0);
        chk("done_rdata", rdata_o, exp_rdata);
    endtask

    initial begin
        int n0;
        int ntx;
        logic [1:0] code;
        logic [1:0] prev_code;
        int gap;
        logic stayed;

        nrst     = 1'b0;
        rwi_i    = 2'b00;
        addr_i   = '0;
        wdata_i  = '0;
        wb_dat_i = '0;
        wb_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_sel", wb_sel_o, 4'b1111);
        chk("rst_err", err_o, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Fetch with ack latency 3, then a held code must not relaunch.
        run_txn(2'b11, 32'h0000_1006, 32'h0, 32'h0051_8193, 3);
        n0 = launches;
        repeat (3) begin
            @(negedge clk);
            chk("hold_no_cyc", wb_cyc_o, 0);
        end
        chk("hold_launch_count", launches, n0);

        // Store then fetch launched directly from HOLD.
        n0 = launches;
        run_txn(2'b01, 32'h0000_2000, 32'hDEAD_00FF, $urandom, 1);
        run_txn(2'b11, 32'h0000_2004, 32'h0, 32'h1234_5678, 2);
        chk("store_fetch_count", launches - n0, 2);

        // Handler-style load sequence: 11 -> 00 -> 10 (held past the edge) -> 11.
        rwi_i = 2'b00;
        @(negedge clk);
        n0 = launches;
        run_txn(2'b11, 32'h0000_3000, 32'h0, 32'h0000_0013, 1);
        rwi_i = 2'b00;
        @(negedge clk);
        run_txn(2'b10, 32'h0000_8000, 32'h0, 32'h8000_0080, 2);
        chk("load_rdata", rdata_o, 32'h8000_0080);
        run_txn(2'b11, 32'h0000_3004, 32'h0, 32'h0000_0033, 1);
        rwi_i = 2'b00;
        @(negedge clk);
        chk("load_seq_count", launches - n0, 3);

        // Spurious ack in IDLE.
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFFFF_0000;
        repeat (3) begin
            @(negedge clk);
            chk("spur_busy", busy_o, 0);
            chk("spur_rdata", rdata_o, exp_rdata);
        end
        wb_ack_i = 1'b0;

        // Randomized transactions with random idle gaps and spurious acks.
        n0 = launches;
        ntx = 0;
        prev_code = 2'b11;
        for (int i = 0; i < 40; i++) begin
            code = 2'($urandom_range(1, 3));
            gap = $urandom_range(0, 2);
            if (code == prev_code && gap == 0) gap = 1;
            if (gap > 0) begin
                rwi_i = 2'b00;
                for (int g = 0; g < gap; g++) begin
                    wb_ack_i = 1'($urandom_range(0, 1));
                    wb_dat_i = $urandom;
                    @(negedge clk);
                end
            end
            run_txn(code, $urandom, $urandom, $urandom, $urandom_range(1, 4));
            ntx++;
            prev_code = code;
        end
        rwi_i = 2'b00;
        @(negedge clk);
        chk("rand_count", launches - n0, ntx);

        // Asynchronous reset during an unacked read.
        rwi_i  = 2'b10;
        addr_i = 32'h0000_4444;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy_o, 1);
        nrst = 1'b0;
        #1;
        chk("async_rst_cyc", wb_cyc_o, 0);
        chk("async_rst_stb", wb_stb_o, 0);
        chk("async_rst_busy", busy_o, 0);
        rwi_i = 2'b00;
        @(negedge clk);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFE_CAFE;
        chk("in_rst_rdata", rdata_o, 0);
        chk("in_rst_adr", wb_adr_o, 0);
        exp_rdata = 32'h0;
        nrst = 1'b1;
        @(negedge clk);
        chk("late_ack_busy", busy_o, 0);
        chk("late_ack_rdata", rdata_o, 0);
        n0 = launches;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk("late_ack_no_cyc", launches, n0);
        run_txn(2'b10, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 2);
        rwi_i = 2'b00;
        @(negedge clk);

`ifdef T07_MMIO_TIMEOUT_EN
        rwi_i  = 2'b10;
        addr_i = 32'h0000_6000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("tmo_busy_high", busy_o, 1);
        end
        @(negedge clk);
        chk("tmo_busy_low", busy_o, 0);
        chk("tmo_rdata", rdata_o, 32'hBAD0_BAD0);
        chk("tmo_err", err_o, 1);
        exp_rdata = 32'hBAD0_BAD0;
        rwi_i = 2'b00;
        @(negedge clk);
        run_txn(2'b11, 32'h0000_6004, 32'h0, 32'h0000_0001, 1);
        chk("tmo_err_sticky", err_o, 1);
`else
        rwi_i  = 2'b10;
        addr_i = 32'h0000_6000;
        @(negedge clk);
        stayed = 1'b1;
        repeat (120) begin
            if (busy_o !== 1'b1) stayed = 1'b0;
            @(negedge clk);
        end
        chk("no_tmo_busy_held", stayed, 1);
        chk("no_tmo_err", err_o, 0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0600_0600;
        @(negedge clk);
        wb_ack_i = 1'b0;
        exp_rdata = 32'h0600_0600;
        chk("no_tmo_done_busy", busy_o, 0);
        chk("no_tmo_rdata", rdata_o, exp_rdata);
`endif
        rwi_i = 2'b00;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
